// File: rtl/mips_rf_pkg.sv
// Shared defaults and reset-contents helper for the MIPS multi-port register file.
package mips_rf_pkg;

    localparam int          RF_DW_DEF   = 32;
    localparam int          RF_NREG_DEF = 32;
    localparam int          RF_AW_DEF   = $clog2(RF_NREG_DEF);
    localparam logic [31:0] RF_INIT_R1  = 32'hFFFF_FFE2;
    localparam logic [31:0] RF_INIT_R2  = 32'h0000_0038;

    // r1/r2 carry the test program operands; every other register resets to its own index.
    function automatic logic [31:0] rf_init_value(input int unsigned idx,
                                                  input logic [31:0] init_r1,
                                                  input logic [31:0] init_r2);
        logic [31:0] val;
        case (idx)
            0:       val = 32'h0;
            1:       val = init_r1;
            2:       val = init_r2;
            default: val = idx;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/mips_rf_scoreboard.sv
// Per-register busy bits: set at issue, cleared by committed writeback, looked up by every read port.
module mips_rf_scoreboard
    import mips_rf_pkg::*;
#(
    parameter int NREG     = RF_NREG_DEF,
    parameter int AW       = $clog2(NREG),
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_WR-1:0]    wr_commit,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic                 sb_set_en,
    input  logic [AW-1:0]        sb_set_addr,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_busy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (reset) begin
            busy_d = '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_commit[p]) busy_d[wr_addr[p*AW +: AW]] = 1'b0;
            end
            // Set after clear: a newly issued producer outranks the one retiring this edge.
            if (sb_set_en && !(ZERO_REG != 0 && sb_set_addr == '0)) busy_d[sb_set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        busy_q <= busy_d;
    end

    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_busy[k] = busy_q[rd_addr[k*AW +: AW]];
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_commit[p] && wr_addr[p*AW +: AW] == rd_addr[k*AW +: AW]) rd_busy[k] = 1'b0;
            end
            if (ZERO_REG != 0 && rd_addr[k*AW +: AW] == '0) rd_busy[k] = 1'b0;
        end
    end

endmodule

// File: rtl/mips_regfile_mp.sv
// Parametrised multi-port MIPS register file with write-first bypass, hardwired r0,
// busy scoreboard and a registered debug read port.
module mips_regfile_mp
    import mips_rf_pkg::*;
#(
    parameter int          DW       = RF_DW_DEF,
    parameter int          NREG     = RF_NREG_DEF,
    parameter int          AW       = $clog2(NREG),
    parameter int          NUM_RD   = 2,
    parameter int          NUM_WR   = 1,
    parameter int          ZERO_REG = 1,
    parameter logic [31:0] INIT_R1  = RF_INIT_R1,
    parameter logic [31:0] INIT_R2  = RF_INIT_R2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    output logic [NUM_RD-1:0]    rd_busy,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic [NUM_WR*DW-1:0] wr_data,
    input  logic                 sb_set_en,
    input  logic [AW-1:0]        sb_set_addr,
    input  logic                 dbg_req,
    input  logic [AW-1:0]        dbg_addr,
    output logic [DW-1:0]        dbg_data,
    output logic                 dbg_valid
);

    localparam int NLK = NUM_RD + 1;

    logic [DW-1:0]     regs_q [NREG];
    logic [DW-1:0]     regs_d [NREG];
    logic [NUM_WR-1:0] wr_commit;
    logic [AW-1:0]     lk_addr [NLK];
    logic [DW-1:0]     lk_data [NLK];
    logic [DW-1:0]     dbg_data_q;
    logic [DW-1:0]     dbg_data_d;
    logic              dbg_valid_q;
    logic              dbg_valid_d;

    // A write commits only outside reset and, with a hardwired r0, only to a non-zero address.
    always_comb begin
        wr_commit = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            wr_commit[p] = wr_en[p] && !reset &&
                           !(ZERO_REG != 0 && wr_addr[p*AW +: AW] == '0);
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_d[i] = DW'(rf_init_value(i, INIT_R1, INIT_R2));
            end
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_commit[p]) regs_d[wr_addr[p*AW +: AW]] = wr_data[p*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end

    // Read ports and the debug port share one lookup path; the last entry is debug.
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) lk_addr[k] = rd_addr[k*AW +: AW];
        lk_addr[NUM_RD] = dbg_addr;
    end

    always_comb begin
        for (int k = 0; k < NLK; k++) begin
            lk_data[k] = regs_q[lk_addr[k]];
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_commit[p] && wr_addr[p*AW +: AW] == lk_addr[k]) lk_data[k] = wr_data[p*DW +: DW];
            end
            if (ZERO_REG != 0 && lk_addr[k] == '0) lk_data[k] = '0;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) rd_data[k*DW +: DW] = lk_data[k];
    end

    always_comb begin
        dbg_valid_d = dbg_req && !reset;
        dbg_data_d  = dbg_data_q;
        if (reset)        dbg_data_d = '0;
        else if (dbg_req) dbg_data_d = lk_data[NUM_RD];
    end

    always_ff @(posedge clk) begin
        dbg_valid_q <= dbg_valid_d;
        dbg_data_q  <= dbg_data_d;
    end

    assign dbg_valid = dbg_valid_q;
    assign dbg_data  = dbg_data_q;

    mips_rf_scoreboard #(
        .NREG     (NREG),
        .AW       (AW),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .wr_commit   (wr_commit),
        .wr_addr     (wr_addr),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .rd_addr     (rd_addr),
        .rd_busy     (rd_busy)
    );

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Directed-vector bench for mips_regfile_mp (2 read ports, 2 write ports, hardwired r0).
module tb_mips_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          reset;
    logic [2*AW-1:0] rd_addr;
    logic [2*DW-1:0] rd_data;
    logic [1:0]    rd_busy;
    logic [1:0]    wr_en;
    logic [2*AW-1:0] wr_addr;
    logic [2*DW-1:0] wr_data;
    logic          sb_set_en;
    logic [AW-1:0] sb_set_addr;
    logic          dbg_req;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;
    logic          dbg_valid;

    int n_vec = 0;
    int n_err = 0;

    mips_regfile_mp #(
        .DW (DW), .NREG (32), .NUM_RD (2), .NUM_WR (2), .ZERO_REG (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .dbg_req     (dbg_req),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .dbg_valid   (dbg_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en     = 2'b00;
        sb_set_en = 1'b0;
        dbg_req   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        sb_set_en = 1'b0; sb_set_addr = '0; dbg_req = 1'b0; dbg_addr = '0;
        tick(); tick();
        reset = 1'b0;

        // reset contents
        rd_addr = {5'd1, 5'd0}; #1;
        chk("rst_r0", rd_data[31:0], 32'h0);
        chk("rst_r1", rd_data[63:32], 32'hFFFF_FFE2);
        rd_addr = {5'd3, 5'd2}; #1;
        chk("rst_r2", rd_data[31:0], 32'h0000_0038);
        chk("rst_r3", rd_data[63:32], 32'h0000_0003);
        chk("rst_busy", {30'h0, rd_busy}, 32'h0);
        chk("rst_dbgv", {31'h0, dbg_valid}, 32'h0);
        chk("rst_dbgd", dbg_data, 32'h0);

        // same-cycle bypass on port 0
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEAD_BEEF};
        rd_addr = {5'd1, 5'd5}; #1;
        chk("byp_r5", rd_data[31:0], 32'hDEAD_BEEF);
        tick(); idle(); #1;
        chk("held_r5", rd_data[31:0], 32'hDEAD_BEEF);

        // r0 hardwired: write and scoreboard set both ignored
        wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'h1234_5678};
        sb_set_en = 1'b1; sb_set_addr = 5'd0; rd_addr = {5'd1, 5'd0}; #1;
        chk("r0_byp", rd_data[31:0], 32'h0);
        chk("r0_busy_now", {31'h0, rd_busy[0]}, 32'h0);
        tick(); idle(); #1;
        chk("r0_after", rd_data[31:0], 32'h0);
        chk("r0_busy_after", {31'h0, rd_busy[0]}, 32'h0);

        // both write ports on r7: port 1 wins, in bypass and in storage
        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h2222_2222, 32'h1111_1111};
        rd_addr = {5'd1, 5'd7}; #1;
        chk("dual_byp", rd_data[31:0], 32'h2222_2222);
        tick(); idle(); #1;
        chk("dual_r7", rd_data[31:0], 32'h2222_2222);

        // scoreboard set then clear on r9
        sb_set_en = 1'b1; sb_set_addr = 5'd9; rd_addr = {5'd9, 5'd0}; #1;
        chk("sb9_pre", {31'h0, rd_busy[1]}, 32'h0);
        tick(); idle(); #1;
        chk("sb9_set", {31'h0, rd_busy[1]}, 32'h1);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'hAAAA_5555}; #1;
        chk("sb9_fwd", {31'h0, rd_busy[1]}, 32'h0);
        chk("r9_byp", rd_data[63:32], 32'hAAAA_5555);
        tick(); idle(); #1;
        chk("sb9_clr", {31'h0, rd_busy[1]}, 32'h0);

        // set and clear on r4 at the same edge: set wins
        sb_set_en = 1'b1; sb_set_addr = 5'd4;
        wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h4444_4444};
        tick(); idle(); rd_addr = {5'd5, 5'd4}; #1;
        chk("sb4_setwin", {31'h0, rd_busy[0]}, 32'h1);
        chk("r4_data", rd_data[31:0], 32'h4444_4444);

        // mid-sequence reset: bypass off during reset, contents and busy restored
        reset = 1'b1; wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h5555_5555}; #1;
        chk("rst_nobyp", rd_data[31:0], 32'h4444_4444);
        tick(); reset = 1'b0; idle(); #1;
        chk("rst2_r4", rd_data[31:0], 32'h0000_0004);
        chk("rst2_r5", rd_data[63:32], 32'h0000_0005);
        chk("rst2_busy4", {31'h0, rd_busy[0]}, 32'h0);
        rd_addr = {5'd9, 5'd7}; #1;
        chk("rst2_r7", rd_data[31:0], 32'h0000_0007);

        // debug: two back-to-back requests on r2
        dbg_req = 1'b1; dbg_addr = 5'd2;
        tick(); #1;
        chk("dbg1_v", {31'h0, dbg_valid}, 32'h1);
        chk("dbg1_d", dbg_data, 32'h0000_0038);
        tick(); dbg_req = 1'b0; #1;
        chk("dbg2_v", {31'h0, dbg_valid}, 32'h1);
        chk("dbg2_d", dbg_data, 32'h0000_0038);
        tick(); #1;
        chk("dbg3_v", {31'h0, dbg_valid}, 32'h0);
        chk("dbg3_hold", dbg_data, 32'h0000_0038);

        // debug sees the bypassed value of a same-cycle write
        dbg_req = 1'b1; dbg_addr = 5'd6;
        wr_en = 2'b10; wr_addr = {5'd6, 5'd0}; wr_data = {32'hCAFE_F00D, 32'h0};
        tick(); idle(); #1;
        chk("dbg_byp_v", {31'h0, dbg_valid}, 32'h1);
        chk("dbg_byp_d", dbg_data, 32'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
